sdram_port_arbiter: RTL and testbench
=====================================

Name: sdram_port_arbiter

Overview:
Two-port arbiter that shares the single SDRAM controller burst interface between the VGA frame-buffer reader (read port) and the frame writer / pattern generator (write port). It sits between both requesters and the SDRAM controller in sdram_vga_exp. It grants one burst at a time and holds the grant until the controller signals burst completion. An urgent read (VGA line FIFO near empty) overrides fairness; otherwise the ports alternate round-robin.

Parameters:
ADDR_W, 22, SDRAM word address width (bank+row+col)
LEN_W, 9, burst length field width, in 16-bit words
DATA_W, 16, SDRAM data width

Ports:
clk  in  1  system clock (SDRAM controller domain)
rst_n  in  1  reset; asynchronous, active-low
rd_req  in  1  read-port burst request, held until rd_gnt
rd_urgent  in  1  VGA FIFO below low watermark
rd_addr  in  ADDR_W  read burst start address
rd_len  in  LEN_W  read burst length in words
rd_gnt  out  1  one-cycle pulse: read request accepted
rd_done  out  1  one-cycle pulse: read burst finished
rd_data_vld  out  1  read data valid, routed from controller
rd_data  out  DATA_W  read data
wr_req  in  1  write-port burst request, held until wr_gnt
wr_addr  in  ADDR_W  write burst start address
wr_len  in  LEN_W  write burst length in words
wr_data  in  DATA_W  write data, presented on wr_data_rd
wr_gnt  out  1  one-cycle pulse: write request accepted
wr_done  out  1  one-cycle pulse: write burst finished
wr_data_rd  out  1  write data pop strobe, routed from controller
mem_req  out  1  burst request to controller, held until mem_ack
mem_we  out  1  1=write burst, 0=read burst
mem_addr  out  ADDR_W  registered burst address
mem_len  out  LEN_W  registered burst length
mem_ack  in  1  controller accepted request
mem_done  in  1  controller finished burst
mem_rdata_vld  in  1  controller read data valid
mem_rdata  in  DATA_W  controller read data
mem_wdata_rd  in  1  controller pops one write word
mem_wdata  out  DATA_W  write data to controller

Behaviour:
- Reset values: all outputs 0; state IDLE; last_served = WR (so first contest goes to read).
- FSM IDLE -> ISSUE -> BUSY -> IDLE.
- IDLE: arbitration each cycle. Priority: rd_req&rd_urgent > round-robin (port not last_served) > any single requester. On a win: register addr/len/we, pulse the winner's gnt in the same cycle, move to ISSUE. mem_req rises the next cycle (1-cycle latency from req to mem_req).
- Zero-length request (len==0): gnt and done pulse together in IDLE, no controller access, last_served unchanged, stay IDLE.
- ISSUE: mem_req=1, mem_addr/len/we stable. On mem_ack: drop mem_req the next cycle and move to BUSY. mem_ack and mem_done in the same cycle: done is handled, go straight to IDLE.
- BUSY: wait for mem_done. Then pulse the owner's done, update last_served=owner, return to IDLE. The next arbitration is allowed in the same cycle as the return (one idle cycle minimum between bursts).
- Data routing (combinational, gated by owner and state!=IDLE):
  - rd_data_vld = mem_rdata_vld & owner==RD; rd_data = mem_rdata always.
  - wr_data_rd = mem_wdata_rd & owner==WR; mem_wdata = wr_data.
  - Strobes arriving while IDLE are dropped.
- rd_urgent is sampled only in IDLE. Urgency never preempts a burst in progress.
- Requester dropping req before gnt: allowed, nothing issued.
- Async reset mid-burst: mem_req and all strobes drop immediately. The controller is reset on the same rst_n.

Decomposition:
- Package sdram_arb_pkg: owner encoding (OWN_RD=0, OWN_WR=1), FSM state encodings (IDLE, ISSUE, BUSY), default widths.
- One natural sub-module: sdram_arb_pick, the combinational priority/round-robin selector (inputs rd_req, rd_urgent, wr_req, last_served, len-zero flags; outputs grant vector).

Test Plan:
- Only rd_req, addr 0x000100, len 256 -> rd_gnt pulse; mem_req next cycle with mem_we=0, addr 0x000100, len 256; after mem_done, rd_done exactly 1 cycle.
- rd_req and wr_req together, non-urgent, after reset -> order RD, WR, RD, WR over four bursts; mem_we toggles 0,1,0,1.
- Write burst in BUSY with rd_urgent raised -> write completes uninterrupted; next grant is RD even though last_served=RD previously.
- Write burst len 8, controller pops 8 mem_wdata_rd -> exactly 8 wr_data_rd pulses, mem_wdata equals wr_data each cycle; rd_data_vld stays 0.
- wr_len=0 request -> wr_gnt and wr_done in the same cycle, mem_req never asserts.
- rst_n asserted low in BUSY -> mem_req, gnt, done and strobes all 0 within the same cycle; after release, IDLE and the first contest goes to RD.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared encodings and default widths for the SDRAM port arbiter
package sdram_arb_pkg;

    localparam int ADDR_W_DEF = 22;
    localparam int LEN_W_DEF  = 9;
    localparam int DATA_W_DEF = 16;

    // Which requester owns the controller for the current burst
    typedef enum logic {
        OWN_RD = 1'b0,
        OWN_WR = 1'b1
    } owner_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/sdram_arb_pick.sv
// rtl/sdram_arb_pick.sv - combinational urgent/round-robin winner selection
module sdram_arb_pick
    import sdram_arb_pkg::*;
(
    input  logic       rd_req,
    input  logic       rd_urgent,
    input  logic       wr_req,
    input  logic       last_served,
    input  logic       rd_len_zero,
    input  logic       wr_len_zero,
    output logic [1:0] grant,
    output logic       zero_len
);

    logic rd_win;
    logic wr_win;

    // Urgent read first, then the port not served last, then whoever is alone
    always_comb begin
        rd_win   = 1'b0;
        wr_win   = 1'b0;
        grant    = 2'b00;
        zero_len = 1'b0;

        rd_win   = rd_req & (rd_urgent | ~wr_req | (last_served == OWN_WR));
        wr_win   = wr_req & ~rd_win;
        grant    = {wr_win, rd_win};
        zero_len = (rd_win & rd_len_zero) | (wr_win & wr_len_zero);
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - shares one SDRAM burst interface between the VGA reader and the frame writer
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_req,
    input  logic              rd_urgent,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [LEN_W-1:0]  rd_len,
    output logic              rd_gnt,
    output logic              rd_done,
    output logic              rd_data_vld,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [LEN_W-1:0]  wr_len,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    output logic              wr_done,
    output logic              wr_data_rd,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LEN_W-1:0]  mem_len,
    input  logic              mem_ack,
    input  logic              mem_done,
    input  logic              mem_rdata_vld,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_wdata_rd,
    output logic [DATA_W-1:0] mem_wdata
);

    arb_state_t state;
    arb_state_t state_nxt;
    owner_t     owner;
    owner_t     owner_nxt;
    owner_t     last_served;
    owner_t     last_nxt;

    logic [1:0] grant;
    logic       zero_len;
    logic       load;
    logic       burst_active;

    sdram_arb_pick u_pick (
        .rd_req      (rd_req),
        .rd_urgent   (rd_urgent),
        .wr_req      (wr_req),
        .last_served (last_served),
        .rd_len_zero (rd_len == '0),
        .wr_len_zero (wr_len == '0),
        .grant       (grant),
        .zero_len    (zero_len)
    );

    // State, owner and fairness history; reset hands the first contest to the reader
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            owner       <= OWN_RD;
            last_served <= OWN_WR;
        end else begin
            state       <= state_nxt;
            owner       <= owner_nxt;
            last_served <= last_nxt;
        end
    end

    // Capture the winning burst descriptor so the controller sees stable values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr <= '0;
            mem_len  <= '0;
            mem_we   <= 1'b0;
        end else if (load) begin
            mem_addr <= grant[1] ? wr_addr : rd_addr;
            mem_len  <= grant[1] ? wr_len : rd_len;
            mem_we   <= grant[1];
        end
    end

    // Next state plus grant/done pulses; rst_n gates IDLE arbitration so nothing pulses in reset
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        last_nxt  = last_served;
        load      = 1'b0;
        rd_gnt    = 1'b0;
        wr_gnt    = 1'b0;
        rd_done   = 1'b0;
        wr_done   = 1'b0;
        mem_req   = 1'b0;

        case (state)
            IDLE: begin
                if (rst_n && (grant != 2'b00)) begin
                    rd_gnt = grant[0];
                    wr_gnt = grant[1];
                    if (zero_len) begin
                        // Nothing to transfer: acknowledge and finish without touching the controller
                        rd_done = grant[0];
                        wr_done = grant[1];
                    end else begin
                        load      = 1'b1;
                        owner_nxt = grant[1] ? OWN_WR : OWN_RD;
                        state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    if (mem_done) begin
                        rd_done   = (owner == OWN_RD);
                        wr_done   = (owner == OWN_WR);
                        last_nxt  = owner;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                if (mem_done) begin
                    rd_done   = (owner == OWN_RD);
                    wr_done   = (owner == OWN_WR);
                    last_nxt  = owner;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Route controller data strobes only to the port that owns the burst
    always_comb begin
        burst_active = (state != IDLE);
        rd_data_vld  = mem_rdata_vld & burst_active & (owner == OWN_RD);
        wr_data_rd   = mem_wdata_rd & burst_active & (owner == OWN_WR);
        rd_data      = mem_rdata;
        mem_wdata    = wr_data;
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - directed self-checking bench for the SDRAM port arbiter
module tb_sdram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        rd_req = 1'b0;
    logic        rd_urgent = 1'b0;
    logic [21:0] rd_addr = '0;
    logic [8:0]  rd_len = '0;
    logic        rd_gnt;
    logic        rd_done;
    logic        rd_data_vld;
    logic [15:0] rd_data;
    logic        wr_req = 1'b0;
    logic [21:0] wr_addr = '0;
    logic [8:0]  wr_len = '0;
    logic [15:0] wr_data = '0;
    logic        wr_gnt;
    logic        wr_done;
    logic        wr_data_rd;
    logic        mem_req;
    logic        mem_we;
    logic [21:0] mem_addr;
    logic [8:0]  mem_len;
    logic        mem_ack = 1'b0;
    logic        mem_done = 1'b0;
    logic        mem_rdata_vld = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic        mem_wdata_rd = 1'b0;
    logic [15:0] mem_wdata;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    sdram_port_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rd_req        (rd_req),
        .rd_urgent     (rd_urgent),
        .rd_addr       (rd_addr),
        .rd_len        (rd_len),
        .rd_gnt        (rd_gnt),
        .rd_done       (rd_done),
        .rd_data_vld   (rd_data_vld),
        .rd_data       (rd_data),
        .wr_req        (wr_req),
        .wr_addr       (wr_addr),
        .wr_len        (wr_len),
        .wr_data       (wr_data),
        .wr_gnt        (wr_gnt),
        .wr_done       (wr_done),
        .wr_data_rd    (wr_data_rd),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_len       (mem_len),
        .mem_ack       (mem_ack),
        .mem_done      (mem_done),
        .mem_rdata_vld (mem_rdata_vld),
        .mem_rdata     (mem_rdata),
        .mem_wdata_rd  (mem_wdata_rd),
        .mem_wdata     (mem_wdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
    endtask

    // Caller raises the request(s) in an IDLE cycle; the task checks grant, issue, busy and done
    task automatic run_burst(input logic exp_wr, input logic [21:0] exp_addr,
                             input logic [8:0] exp_len, input int pops, input logic urg);
        int npop;
        npop = 0;
        @(negedge clk);
        chk("gnt_rd", rd_gnt, !exp_wr);
        chk("gnt_wr", wr_gnt, exp_wr);
        chk("idle_mem_req", mem_req, 0);
        chk("idle_done", rd_done | wr_done, 0);
        tick;
        if (exp_wr) wr_req = 1'b0;
        else rd_req = 1'b0;
        mem_ack = 1'b1;
        @(negedge clk);
        chk("mem_req", mem_req, 1);
        chk("mem_we", mem_we, exp_wr);
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_len", mem_len, exp_len);
        chk("issue_gnt", rd_gnt | wr_gnt, 0);
        tick;
        mem_ack = 1'b0;
        if (urg) begin
            rd_req = 1'b1;
            rd_urgent = 1'b1;
        end
        @(negedge clk);
        chk("busy_mem_req", mem_req, 0);
        for (int k = 0; k < pops; k++) begin
            tick;
            wr_data = 16'(16'hA000 + k);
            mem_wdata_rd = 1'b1;
            mem_rdata_vld = 1'b1;
            @(negedge clk);
            chk("mem_wdata", mem_wdata, 16'(16'hA000 + k));
            chk("rd_vld_gated", rd_data_vld, !exp_wr);
            chk("busy_no_preempt", rd_gnt, 0);
            npop += int'(wr_data_rd);
        end
        tick;
        mem_wdata_rd = 1'b0;
        mem_rdata_vld = 1'b0;
        mem_done = 1'b1;
        @(negedge clk);
        chk("done_rd", rd_done, !exp_wr);
        chk("done_wr", wr_done, exp_wr);
        chk("done_no_gnt", rd_gnt | wr_gnt, 0);
        if (pops > 0) chk("pop_count", npop, pops);
        tick;
        mem_done = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        // Reset with every input active: all outputs must stay low
        rd_req = 1'b1;
        wr_req = 1'b1;
        rd_len = 9'd4;
        wr_len = 9'd4;
        mem_ack = 1'b1;
        mem_done = 1'b1;
        mem_rdata_vld = 1'b1;
        mem_wdata_rd = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_gnt", {30'd0, rd_gnt, wr_gnt}, 0);
        chk("rst_done", {30'd0, rd_done, wr_done}, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_len", mem_len, 0);
        chk("rst_strobes", {30'd0, rd_data_vld, wr_data_rd}, 0);
        rd_req = 1'b0;
        wr_req = 1'b0;
        mem_ack = 1'b0;
        mem_done = 1'b0;
        mem_rdata_vld = 1'b0;
        mem_wdata_rd = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;

        // Single read burst
        rd_addr = 22'h000100;
        rd_len = 9'd256;
        rd_req = 1'b1;
        run_burst(1'b0, 22'h000100, 9'd256, 0, 1'b0);

        // Round-robin after a fresh reset: RD, WR, RD, WR
        do_reset;
        rd_addr = 22'h001000;
        wr_addr = 22'h002000;
        rd_len = 9'd4;
        wr_len = 9'd4;
        for (int i = 0; i < 4; i++) begin
            rd_req = 1'b1;
            wr_req = 1'b1;
            run_burst(i[0], i[0] ? 22'h002000 : 22'h001000, 9'd4, 0, 1'b0);
        end
        rd_req = 1'b0;
        wr_req = 1'b0;

        // Read, then an 8-word write that urgency must not interrupt, then the urgent read
        rd_req = 1'b1;
        run_burst(1'b0, 22'h001000, 9'd4, 0, 1'b0);
        wr_addr = 22'h003000;
        wr_len = 9'd8;
        wr_req = 1'b1;
        run_burst(1'b1, 22'h003000, 9'd8, 8, 1'b1);
        run_burst(1'b0, 22'h001000, 9'd4, 0, 1'b0);

        // Urgent read beats a waiting writer even though the reader was served last
        wr_len = 9'd4;
        rd_req = 1'b1;
        wr_req = 1'b1;
        rd_urgent = 1'b1;
        run_burst(1'b0, 22'h001000, 9'd4, 0, 1'b0);

        // Zero-length write: gnt and done together, no controller access, strobes dropped in IDLE
        rd_urgent = 1'b0;
        wr_len = 9'd0;
        mem_wdata_rd = 1'b1;
        mem_rdata_vld = 1'b1;
        @(negedge clk);
        chk("zl_gnt", wr_gnt, 1);
        chk("zl_done", wr_done, 1);
        chk("zl_rd_gnt", rd_gnt, 0);
        chk("zl_mem_req", mem_req, 0);
        chk("idle_strobes", {30'd0, rd_data_vld, wr_data_rd}, 0);
        tick;
        wr_req = 1'b0;
        wr_len = 9'd4;
        mem_wdata_rd = 1'b0;
        mem_rdata_vld = 1'b0;
        @(negedge clk);
        chk("zl_mem_req_after", mem_req, 0);
        chk("zl_done_after", wr_done, 0);
        tick;
        // Last real burst was RD, so the write wins a non-urgent contest
        wr_addr = 22'h004000;
        rd_req = 1'b1;
        wr_req = 1'b1;
        run_burst(1'b1, 22'h004000, 9'd4, 0, 1'b0);
        rd_req = 1'b0;

        // Asynchronous reset in the middle of a write burst
        rd_req = 1'b1;
        run_burst(1'b0, 22'h001000, 9'd4, 0, 1'b0);
        wr_req = 1'b1;
        @(negedge clk);
        chk("pre_rst_gnt", wr_gnt, 1);
        tick;
        wr_req = 1'b0;
        mem_ack = 1'b1;
        tick;
        mem_ack = 1'b0;
        mem_wdata_rd = 1'b1;
        mem_done = 1'b1;
        #2;
        chk("pre_rst_pop", wr_data_rd, 1);
        chk("pre_rst_done", wr_done, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mem_req", mem_req, 0);
        chk("mid_rst_done", wr_done, 0);
        chk("mid_rst_pop", wr_data_rd, 0);
        chk("mid_rst_gnt", wr_gnt, 0);
        mem_wdata_rd = 1'b0;
        mem_done = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
        rd_req = 1'b1;
        wr_req = 1'b1;
        run_burst(1'b0, 22'h001000, 9'd4, 0, 1'b0);
        rd_req = 1'b0;
        wr_req = 1'b0;
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
